// File: rtl/ita_activation_pipe.sv
// ita_activation_pipe: N-lane, 3-stage identity / ReLU / i-GELU activation unit
// with elastic valid/ready flow, idle-only config load and an output beat counter.
module ita_activation_pipe #(
  parameter int N       = 16,
  parameter int IN_W    = 8,
  parameter int CONST_W = 18,
  parameter int OUT_W   = 24
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [1:0]           cfg_mode_i,
  input  logic [CONST_W-1:0]   cfg_one_i,
  input  logic [CONST_W-1:0]   cfg_b_i,
  input  logic [CONST_W-1:0]   cfg_c_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [N*IN_W-1:0]    data_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [N*OUT_W-1:0]   data_o,
  output logic                 busy_o,
  output logic [31:0]          beat_cnt_o
);

  localparam int M_W = IN_W + 1;        // |x| without overflow at the most negative input
  localparam int A_W = CONST_W + 2;     // clipped magnitude and -b
  localparam int P_W = 2 * CONST_W + 2; // polynomial / erf width
  localparam int E_W = P_W + 1;         // erf + one
  localparam int Y_W = IN_W + E_W;      // full-precision product before saturation

  localparam logic [1:0] MODE_RELU = 2'b01;
  localparam logic [1:0] MODE_GELU = 2'b10;

  logic [1:0]                 mode_q;
  logic signed [CONST_W-1:0]  one_q, b_q, c_q;

  logic                       s1_v_q, s2_v_q, s3_v_q;
  logic [1:0]                 s1_mode_q, s2_mode_q;
  logic signed [IN_W-1:0]     s1_x_q   [N];
  logic                       s1_neg_q [N];
  logic signed [A_W-1:0]      s1_a_q   [N];
  logic signed [IN_W-1:0]     s2_x_q   [N];
  logic signed [P_W-1:0]      s2_erf_q [N];
  logic [N*OUT_W-1:0]         data_q;
  logic [31:0]                cnt_q;

  logic signed [IN_W-1:0]     x_d   [N];
  logic signed [A_W-1:0]      a_d   [N];
  logic signed [P_W-1:0]      erf_d [N];
  logic [N*OUT_W-1:0]         y_d;

  logic busy, cfg_we, s1_en, s1_adv, s2_adv, accept;

  // Each stage may take a new beat when empty or when its contents move on this cycle.
  assign busy    = s1_v_q | s2_v_q | s3_v_q;
  assign cfg_we  = cfg_valid_i & ~busy;
  assign s2_adv  = ~s3_v_q | ready_i;
  assign s1_adv  = ~s2_v_q | s2_adv;
  assign s1_en   = ~s1_v_q | s1_adv;
  assign ready_o = ~cfg_we & s1_en;
  assign accept  = valid_i & ready_o;

  assign cfg_ready_o = ~busy;
  assign busy_o      = busy;
  assign valid_o     = s3_v_q;
  assign data_o      = data_q;
  assign beat_cnt_o  = cnt_q;

  for (genvar k = 0; k < N; k++) begin : g_lane
    logic signed [M_W-1:0]  x_ext, mag;
    logic signed [A_W-1:0]  mag_w, neg_b;
    logic signed [P_W-1:0]  sum_w, sq, p;
    logic signed [E_W-1:0]  e1;
    logic signed [Y_W-1:0]  x_w, y_gelu, y_sel;
    logic                   fits;

    // S1: clip |x| at -b
    assign x_d[k]  = data_i[k*IN_W +: IN_W];
    assign x_ext   = M_W'(x_d[k]);
    assign mag     = x_d[k][IN_W-1] ? -x_ext : x_ext;
    assign mag_w   = A_W'(mag);
    assign neg_b   = -A_W'(b_q);
    assign a_d[k]  = (mag_w < neg_b) ? mag_w : neg_b;

    // S2: second-order polynomial, sign restored from x
    assign sum_w    = P_W'(s1_a_q[k]) + P_W'(b_q);
    assign sq       = sum_w * sum_w;
    assign p        = sq + P_W'(c_q);
    assign erf_d[k] = s1_neg_q[k] ? -p : p;

    // S3: mode select and saturation to OUT_W
    assign e1     = E_W'(s2_erf_q[k]) + E_W'(one_q);
    assign x_w    = Y_W'(s2_x_q[k]);
    assign y_gelu = x_w * Y_W'(e1);

    always_comb begin
      y_sel = x_w;
      if (s2_mode_q == MODE_GELU)      y_sel = y_gelu;
      else if (s2_mode_q == MODE_RELU) y_sel = s2_x_q[k][IN_W-1] ? '0 : x_w;
    end

    assign fits = (&y_sel[Y_W-1:OUT_W-1]) | ~(|y_sel[Y_W-1:OUT_W-1]);
    assign y_d[k*OUT_W +: OUT_W] = fits ? y_sel[OUT_W-1:0]
                                 : (y_sel[Y_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                 : {1'b0, {(OUT_W-1){1'b1}}});
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q    <= '0;
      one_q     <= '0;
      b_q       <= '0;
      c_q       <= '0;
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s3_v_q    <= 1'b0;
      s1_mode_q <= '0;
      s2_mode_q <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      for (int k = 0; k < N; k++) begin
        s1_x_q[k]   <= '0;
        s1_neg_q[k] <= 1'b0;
        s1_a_q[k]   <= '0;
        s2_x_q[k]   <= '0;
        s2_erf_q[k] <= '0;
      end
    end else begin
      if (cfg_we) begin
        mode_q <= cfg_mode_i;
        one_q  <= cfg_one_i;
        b_q    <= cfg_b_i;
        c_q    <= cfg_c_i;
      end

      if (s1_en) begin
        s1_v_q <= accept;
        if (accept) begin
          s1_mode_q <= mode_q;
          for (int k = 0; k < N; k++) begin
            s1_x_q[k]   <= x_d[k];
            s1_neg_q[k] <= x_d[k][IN_W-1];
            s1_a_q[k]   <= a_d[k];
          end
        end
      end

      if (s1_adv) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          s2_mode_q <= s1_mode_q;
          for (int k = 0; k < N; k++) begin
            s2_x_q[k]   <= s1_x_q[k];
            s2_erf_q[k] <= erf_d[k];
          end
        end
      end

      if (s2_adv) begin
        s3_v_q <= s2_v_q;
        if (s2_v_q) data_q <= y_d;
      end

      if (s3_v_q && ready_i) cnt_q <= cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_ita_activation_pipe.sv
// Directed bench for ita_activation_pipe: table of single-beat vectors plus
// hand-written backpressure, config-guard and mid-stream reset sequences.
module tb_ita_activation_pipe;
  localparam int N = 16, IN_W = 8, CONST_W = 18, OUT_W = 24;

  logic clk, rst_n;
  logic cfg_valid, cfg_ready;
  logic [1:0] cfg_mode;
  logic [CONST_W-1:0] cfg_one, cfg_b, cfg_c;
  logic valid_i, ready_o, valid_o, ready_i, busy;
  logic [N*IN_W-1:0] data_i;
  logic [N*OUT_W-1:0] data_o;
  logic [31:0] beat_cnt;

  int total = 0;
  int bad = 0;

  ita_activation_pipe #(.N(N), .IN_W(IN_W), .CONST_W(CONST_W), .OUT_W(OUT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_mode_i(cfg_mode),
    .cfg_one_i(cfg_one), .cfg_b_i(cfg_b), .cfg_c_i(cfg_c),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .busy_o(busy), .beat_cnt_o(beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    int one, b, c, x, y;
    bit spread;
  } vec_t;

  vec_t vt[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [N*OUT_W-1:0] act,
                           input logic [N*OUT_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [N*IN_W-1:0] lanes_in(input int x, input bit spread);
    logic [N*IN_W-1:0] d;
    d = '0;
    for (int k = 0; k < N; k++) d[k*IN_W +: IN_W] = IN_W'(spread ? x + k : x);
    return d;
  endfunction

  function automatic logic [N*OUT_W-1:0] lanes_out(input vec_t v);
    logic [N*OUT_W-1:0] d;
    int xk, yk;
    d = '0;
    for (int k = 0; k < N; k++) begin
      xk = v.x + k;
      if (k == 0 || !v.spread) yk = v.y;
      else if (v.mode == 2'b01) yk = (xk < 0) ? 0 : xk;
      else yk = xk;
      d[k*OUT_W +: OUT_W] = OUT_W'(yk);
    end
    return d;
  endfunction

  function automatic logic [N*OUT_W-1:0] all_lanes(input int y);
    logic [N*OUT_W-1:0] d;
    for (int k = 0; k < N; k++) d[k*OUT_W +: OUT_W] = OUT_W'(y);
    return d;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic cfg_write(input logic [1:0] m, input int one, input int b, input int c);
    cfg_valid = 1'b1;
    cfg_mode  = m;
    cfg_one   = CONST_W'(one);
    cfg_b     = CONST_W'(b);
    cfg_c     = CONST_W'(c);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!valid_o && n < 10) begin
      tick();
      n++;
    end
  endtask

  // One beat in, wait for it, compare, let it drain.
  task automatic send_and_check(input string name, input logic [N*IN_W-1:0] d,
                                input logic [N*OUT_W-1:0] exp);
    int n;
    valid_i = 1'b1;
    data_i  = d;
    #1;
    check({name, "_ready"}, longint'(ready_o), 1);
    tick();
    valid_i = 1'b0;
    wait_out(n);
    check({name, "_latency"}, n, 2);
    check_vec(name, data_o, exp);
    tick();
  endtask

  function automatic logic [N*IN_W-1:0] bp_in(input int i);
    logic [N*IN_W-1:0] d;
    for (int k = 0; k < N; k++) d[k*IN_W +: IN_W] = IN_W'(i * 10 + k);
    return d;
  endfunction

  function automatic logic [N*OUT_W-1:0] bp_out(input int i);
    logic [N*OUT_W-1:0] d;
    for (int k = 0; k < N; k++) d[k*OUT_W +: OUT_W] = OUT_W'(i * 10 + k);
    return d;
  endfunction

  initial begin
    int n, in_idx, out_idx, drops, saw_v;
    bit prev_stall;
    logic [N*OUT_W-1:0] prev_data;

    vt[0]  = '{2'b10, 16, -4, -20, 3, -9, 1'b0};
    vt[1]  = '{2'b10, 16, -4, -20, -3, -105, 1'b0};
    vt[2]  = '{2'b10, 16, -4, -20, 5, -20, 1'b0};
    vt[3]  = '{2'b10, 16, -4, -20, 0, 0, 1'b0};
    vt[4]  = '{2'b10, 16, -4, -20, -128, -4608, 1'b0};
    vt[5]  = '{2'b10, 131071, -1, 0, 127, 8388607, 1'b0};
    vt[6]  = '{2'b10, 131071, -1, 0, -128, -8388608, 1'b0};
    vt[7]  = '{2'b01, 0, 0, 0, -7, 0, 1'b1};
    vt[8]  = '{2'b01, 0, 0, 0, 7, 7, 1'b1};
    vt[9]  = '{2'b00, 0, 0, 0, -7, -7, 1'b1};
    vt[10] = '{2'b00, 0, 0, 0, 7, 7, 1'b1};
    vt[11] = '{2'b11, 0, 0, 0, -7, -7, 1'b1};
    vt[12] = '{2'b11, 0, 0, 0, 7, 7, 1'b1};
    vt[13] = '{2'b10, 16, -200, -20, 100, 999600, 1'b0};
    vt[14] = '{2'b10, 16, -200, -20, -100, 996400, 1'b0};

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_mode = '0; cfg_one = '0; cfg_b = '0; cfg_c = '0;
    valid_i = 1'b0; data_i = '0; ready_i = 1'b1;

    // reset state
    tick();
    tick();
    check("rst_valid_o", longint'(valid_o), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_beat_cnt", longint'(beat_cnt), 0);
    check_vec("rst_data_o", data_o, '0);
    rst_n = 1'b1;
    tick();
    check("idle_cfg_ready", longint'(cfg_ready), 1);

    for (int i = 0; i < 15; i++) begin
      cfg_write(vt[i].mode, vt[i].one, vt[i].b, vt[i].c);
      send_and_check($sformatf("vec%0d", i), lanes_in(vt[i].x, vt[i].spread), lanes_out(vt[i]));
    end

    // backpressure: 10 beats, ready_i low in cycles 4..8, identity mode after reset
    do_reset();
    in_idx = 0; out_idx = 0; drops = 0; prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 60 && out_idx < 10; c++) begin
      ready_i = !(c >= 4 && c <= 8);
      valid_i = (in_idx < 10);
      data_i  = bp_in(in_idx);
      #1;
      if (prev_stall) begin
        check("bp_stall_valid", longint'(valid_o), 1);
        check_vec("bp_stall_data", data_o, prev_data);
      end
      if (valid_i && !ready_o) drops++;
      if (valid_o && ready_i) begin
        check_vec($sformatf("bp_beat%0d", out_idx), data_o, bp_out(out_idx));
        out_idx++;
      end
      if (valid_i && ready_o) in_idx++;
      prev_stall = valid_o && !ready_i;
      prev_data  = data_o;
      tick();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    check("bp_in_count", in_idx, 10);
    check("bp_out_count", out_idx, 10);
    check("bp_ready_dropped", longint'(drops > 0), 1);
    check("bp_beat_cnt", longint'(beat_cnt), 10);

    // config guard: write while busy is refused, old constants stay in force
    cfg_write(2'b10, 16, -4, -20);
    valid_i = 1'b1;
    data_i  = lanes_in(3, 1'b0);
    tick();
    valid_i   = 1'b0;
    cfg_valid = 1'b1;
    cfg_mode  = 2'b00; cfg_one = '0; cfg_b = '0; cfg_c = '0;
    #1;
    check("guard_busy", longint'(busy), 1);
    check("guard_cfg_ready", longint'(cfg_ready), 0);
    tick();
    cfg_valid = 1'b0;
    wait_out(n);
    check_vec("guard_old_consts", data_o, all_lanes(-9));
    tick();

    // simultaneous config and data while idle: config wins
    cfg_valid = 1'b1;
    cfg_mode  = 2'b01;
    valid_i   = 1'b1;
    data_i    = lanes_in(-7, 1'b0);
    #1;
    check("simul_cfg_ready", longint'(cfg_ready), 1);
    check("simul_ready_o", longint'(ready_o), 0);
    tick();
    cfg_valid = 1'b0;
    valid_i   = 1'b0;
    saw_v = 0;
    for (int i = 0; i < 5; i++) begin
      if (valid_o || busy) saw_v++;
      tick();
    end
    check("simul_no_beat", saw_v, 0);
    send_and_check("simul_relu", lanes_in(-7, 1'b0), all_lanes(0));

    // reset with three beats in flight
    cfg_write(2'b10, 16, -4, -20);
    valid_i = 1'b1;
    data_i  = lanes_in(3, 1'b0);
    tick();
    tick();
    tick();
    valid_i = 1'b0;
    check("flight_full", longint'(valid_o && busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid_o", longint'(valid_o), 0);
    check("mid_rst_busy", longint'(busy), 0);
    check("mid_rst_beat_cnt", longint'(beat_cnt), 0);
    check_vec("mid_rst_data_o", data_o, '0);
    tick();
    rst_n = 1'b1;
    saw_v = 0;
    for (int i = 0; i < 5; i++) begin
      if (valid_o || busy) saw_v++;
      tick();
    end
    check("post_rst_quiet", saw_v, 0);
    send_and_check("post_rst_identity", lanes_in(-7, 1'b0), all_lanes(-7));
    check("post_rst_beat_cnt", longint'(beat_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
